axi_w_misrouting: RTL and testbench

Write-direction decode-error responder. It terminates AXI write transactions whose address decodes to no slave.
- Accepts one AW request, sinks every W beat through WLAST, discards the data, then returns one B response with BRESP=DECERR (2'b11) and the latched AWID.
- Sits behind the interconnect address decoder as the default write target, paired with the read-side misrouting responder.
- Channels are packed vectors with VALID/READY handshakes.

---
 rtl/axi_w_misrouting_pkg.sv | 35 +++
 rtl/axi_w_misrouting.sv | 111 +++++++++++
 tb/tb_axi_w_misrouting.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_w_misrouting_pkg.sv
// Shared definitions for the read/write decode-error responders:
// response codes, packed channel field positions and FSM state encoding.
package axi_w_misrouting_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int AXI_LEN_WIDTH = 8;

  // Single-bit fields sit at the LSB of the W and R vectors; BRESP/RRESP start at bit 0 of B.
  localparam int W_LAST_BIT   = 0;
  localparam int R_LAST_BIT   = 0;
  localparam int B_RESP_LSB   = 0;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_DATA_ENC = 2'd1;
  localparam logic [1:0] ST_RESP_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_DATA = ST_DATA_ENC,
    ST_RESP = ST_RESP_ENC
  } misr_state_e;

  // ID occupies the MSBs of the AW/AR vectors.
  function automatic int chan_id_lsb(input int chan_width, input int id_width);
    return chan_width - id_width;
  endfunction

  // AxLEN sits directly below the ID field.
  function automatic int chan_len_lsb(input int chan_width, input int id_width);
    return chan_width - id_width - AXI_LEN_WIDTH;
  endfunction

endpackage

// File: rtl/axi_w_misrouting.sv
// Default write target: accepts one AW, sinks W through WLAST, answers DECERR on B.
// Flags bursts whose WLAST position disagrees with AWLEN via a one-cycle LEN_ERR_o pulse.
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | ready for a new AW request
// DATA    | sinking W beats until WLAST
// RESP    | presenting {id_q, DECERR} on B until accepted
module axi_w_misrouting
  import axi_w_misrouting_pkg::*;
#(
  parameter int AXI_ID_WIDTH     = 1,
  parameter int AXI_DATA_WIDTH   = 32,
  parameter int AXI_ADDR_WIDTH   = 8,
  parameter int AXI_AWCHAN_WIDTH = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 8 + 3 + 2,
  parameter int AXI_WCHAN_WIDTH  = AXI_DATA_WIDTH + AXI_DATA_WIDTH / 8 + 1,
  parameter int AXI_BCHAN_WIDTH  = AXI_ID_WIDTH + 2
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic [AXI_AWCHAN_WIDTH-1:0] S_AXI_AWCH_i,
  input  logic                        S_AXI_AWCH_VALID_i,
  output logic                        S_AXI_AWCH_READY_o,
  input  logic [AXI_WCHAN_WIDTH-1:0]  S_AXI_WCH_i,
  input  logic                        S_AXI_WCH_VALID_i,
  output logic                        S_AXI_WCH_READY_o,
  output logic [AXI_BCHAN_WIDTH-1:0]  S_AXI_BCH_o,
  output logic                        S_AXI_BCH_VALID_o,
  input  logic                        S_AXI_BCH_READY_i,
  output logic                        LEN_ERR_o
);

  localparam int AW_ID_LSB  = chan_id_lsb(AXI_AWCHAN_WIDTH, AXI_ID_WIDTH);
  localparam int AW_LEN_LSB = chan_len_lsb(AXI_AWCHAN_WIDTH, AXI_ID_WIDTH);

  misr_state_e             state_q;
  logic [AXI_ID_WIDTH-1:0] id_q;
  logic [7:0]              len_q;
  logic [7:0]              beat_cnt_q;
  logic                    late_q;
  logic                    len_err_q;

  logic                    w_last;
  logic [AXI_ID_WIDTH-1:0] aw_id;
  logic [7:0]              aw_len;
  logic                    len_match;
  logic                    unused_bits;

  assign w_last    = S_AXI_WCH_i[W_LAST_BIT];
  assign aw_id     = S_AXI_AWCH_i[AW_ID_LSB +: AXI_ID_WIDTH];
  assign aw_len    = S_AXI_AWCH_i[AW_LEN_LSB +: AXI_LEN_WIDTH];
  assign len_match = (beat_cnt_q == len_q);

  // Address/size/burst and the whole W payload are deliberately discarded.
  assign unused_bits = ^{S_AXI_AWCH_i[AW_LEN_LSB-1:0], S_AXI_WCH_i[AXI_WCHAN_WIDTH-1:1]};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= ST_IDLE;
      id_q       <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      late_q     <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (S_AXI_AWCH_VALID_i) begin
            id_q       <= aw_id;
            len_q      <= aw_len;
            beat_cnt_q <= '0;
            late_q     <= 1'b0;
            state_q    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (S_AXI_WCH_VALID_i) begin
            if (beat_cnt_q != 8'hFF) begin
              beat_cnt_q <= beat_cnt_q + 8'd1;
            end
            // late_q keeps an overlong burst to a single error pulse, even once
            // the saturated counter keeps matching len_q=255.
            if (w_last) begin
              state_q <= ST_RESP;
              if (!len_match && !late_q) begin
                len_err_q <= 1'b1;
              end
            end else if (len_match && !late_q) begin
              len_err_q <= 1'b1;
              late_q    <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          if (S_AXI_BCH_READY_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign S_AXI_AWCH_READY_o = (state_q == ST_IDLE);
  assign S_AXI_WCH_READY_o  = (state_q == ST_DATA);
  assign S_AXI_BCH_VALID_o  = (state_q == ST_RESP);
  assign S_AXI_BCH_o        = {id_q, RESP_DECERR};
  assign LEN_ERR_o          = len_err_q;

endmodule

// File: tb/tb_axi_w_misrouting.sv
// Randomized bench for the write decode-error responder against a transaction-level model.
module tb_axi_w_misrouting;

  localparam int IDW  = 1;
  localparam int DW   = 32;
  localparam int ADW  = 8;
  localparam int AWW  = IDW + ADW + 8 + 3 + 2;
  localparam int WW   = DW + DW / 8 + 1;
  localparam int BW   = IDW + 2;
  localparam int AWLO = AWW - IDW - 8;

  logic           ACLK = 1'b0;
  logic           ARESETN = 1'b0;
  logic [AWW-1:0] awch = '0;
  logic           awvalid = 1'b0;
  logic           awready;
  logic [WW-1:0]  wch = '0;
  logic           wvalid = 1'b0;
  logic           wready;
  logic [BW-1:0]  bch;
  logic           bvalid;
  logic           bready = 1'b0;
  logic           len_err;

  always #5 ACLK = ~ACLK;

  axi_w_misrouting #(
    .AXI_ID_WIDTH  (IDW),
    .AXI_DATA_WIDTH(DW),
    .AXI_ADDR_WIDTH(ADW)
  ) dut (
    .ACLK              (ACLK),
    .ARESETN           (ARESETN),
    .S_AXI_AWCH_i      (awch),
    .S_AXI_AWCH_VALID_i(awvalid),
    .S_AXI_AWCH_READY_o(awready),
    .S_AXI_WCH_i       (wch),
    .S_AXI_WCH_VALID_i (wvalid),
    .S_AXI_WCH_READY_o (wready),
    .S_AXI_BCH_o       (bch),
    .S_AXI_BCH_VALID_o (bvalid),
    .S_AXI_BCH_READY_i (bready),
    .LEN_ERR_o         (len_err)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Passive monitor, sampled on the falling edge.
  int            w_cnt = 0;
  int            err_cnt = 0;
  int            aw_busy_cnt = 0;
  logic          busy = 1'b0;
  logic          b_hold = 1'b0;
  logic [BW-1:0] b_prev = '0;

  always @(negedge ACLK) begin
    if (!ARESETN) begin
      b_hold = 1'b0;
    end else begin
      if (wvalid && wready) w_cnt++;
      if (len_err) err_cnt++;
      if (busy && awready) aw_busy_cnt++;
      if (b_hold) chk("b_stable", {bvalid, bch}, {1'b1, b_prev});
      b_hold = bvalid && !bready;
      b_prev = bch;
    end
  end

  task automatic drive_w(input logic last);
    logic [DW-1:0]   d;
    logic [DW/8-1:0] s;
    d = DW'($urandom());
    s = (DW/8)'($urandom());
    wch = {d, s, last};
    wvalid = 1'b1;
  endtask

  // Entered and left at posedge+1. Model: nbeats handshakes, one error iff nbeats != len+1,
  // B = {id, DECERR}.
  task automatic run_txn(input int id, input int len, input int nbeats, input int bstall,
                         input int wpre, input int gappct);
    int   b;
    int   w0;
    int   e0;
    int   exp_err;
    logic hs;
    logic first;
    w0 = w_cnt;
    e0 = err_cnt;
    aw_busy_cnt = 0;
    exp_err = (nbeats != len + 1) ? 1 : 0;

    if (wpre > 0) begin
      drive_w(nbeats == 1);
      repeat (wpre) begin
        @(negedge ACLK);
        chk("w_ready_pre", wready, 1'b0);
        @(posedge ACLK); #1;
      end
    end

    awch = {IDW'(id), 8'(len), AWLO'($urandom())};
    awvalid = 1'b1;
    hs = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge ACLK);
      if (awready) begin
        hs = 1'b1;
        break;
      end
      @(posedge ACLK); #1;
    end
    chk("aw_accept", hs, 1'b1);
    @(posedge ACLK); #1;
    awvalid = 1'b0;
    busy = 1'b1;

    b = 0;
    first = 1'b1;
    for (int c = 0; c < 4000 && b < nbeats; c++) begin
      if (!wvalid && $urandom_range(99) >= gappct) drive_w(b == nbeats - 1);
      @(negedge ACLK);
      if (first) chk("w_ready_lat", wready, 1'b1);
      first = 1'b0;
      hs = wvalid && wready;
      @(posedge ACLK); #1;
      if (hs) begin
        b++;
        wvalid = 1'b0;
      end
    end
    chk("w_done", b, nbeats);

    @(negedge ACLK);
    chk("b_lat", bvalid, 1'b1);
    repeat (bstall) begin
      @(posedge ACLK); #1;
      @(negedge ACLK);
    end
    @(posedge ACLK); #1;
    bready = 1'b1;
    @(negedge ACLK);
    chk("b_resp", {bvalid, bch}, {1'b1, IDW'(id), 2'b11});
    @(posedge ACLK); #1;
    bready = 1'b0;
    busy = 1'b0;
    @(negedge ACLK);
    chk("aw_ready_lat", awready, 1'b1);
    chk("w_beats", w_cnt - w0, nbeats);
    chk("len_err", err_cnt - e0, exp_err);
    chk("aw_busy", aw_busy_cnt, 0);
    @(posedge ACLK); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_awready"}, awready, 1'b1);
    chk({tag, "_wready"}, wready, 1'b0);
    chk({tag, "_bvalid"}, bvalid, 1'b0);
    chk({tag, "_bch"}, bch, {IDW'(0), 2'b11});
    chk({tag, "_len_err"}, len_err, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int nb;
    repeat (3) @(posedge ACLK);
    #1;
    check_reset_outputs("rst");
    ARESETN = 1'b1;
    @(posedge ACLK); #1;

    run_txn(1, 0, 1, 0, 0, 0);       // single beat
    run_txn(0, 3, 4, 5, 0, 40);      // 4-beat with gaps and B stall
    run_txn(1, 3, 2, 0, 0, 0);       // early WLAST
    run_txn(0, 1, 4, 0, 0, 0);       // late WLAST
    run_txn(1, 0, 1, 0, 3, 0);       // W presented before AW
    run_txn(0, 255, 256, 1, 0, 20);  // longest legal burst
    run_txn(1, 255, 258, 0, 0, 0);   // overlong past counter saturation

    // Reset in the middle of a 4-beat burst.
    awch = {IDW'(1), 8'd3, AWLO'($urandom())};
    awvalid = 1'b1;
    @(posedge ACLK); #1;
    awvalid = 1'b0;
    repeat (2) begin
      drive_w(1'b0);
      @(posedge ACLK); #1;
    end
    #2;
    ARESETN = 1'b0;
    #1;
    check_reset_outputs("midrst");
    wvalid = 1'b0;
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    run_txn(0, 0, 1, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      len = $urandom_range(0, 7);
      nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : len + 1;
      run_txn($urandom_range(0, (1 << IDW) - 1), len, nb, $urandom_range(0, 3),
              $urandom_range(0, 2), $urandom_range(0, 30));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
